// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the instruction queue.
//   master : the surrounding pipeline (drives fetch data, decode ready, flush)
//   slave  : the queue itself (drives f_ready, head entry, halt_seen, count)
interface if_id_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          f_valid;
  logic          f_ready;
  logic [15:0]   f_instr;
  logic [15:0]   f_pc2;
  logic          d_valid;
  logic          d_ready;
  logic [15:0]   d_instr;
  logic [15:0]   d_pc2;
  logic          flush;
  logic          halt_seen;
  logic [CW-1:0] count;

  modport master (
    output f_valid, f_instr, f_pc2, d_ready, flush,
    input  f_ready, d_valid, d_instr, d_pc2, halt_seen, count
  );

  modport slave (
    input  f_valid, f_instr, f_pc2, d_ready, flush,
    output f_ready, d_valid, d_instr, d_pc2, halt_seen, count
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: instruction buffer between fetch and decode.
//   Circular buffer of DEPTH {instr, pc2} entries. Push/pop via valid/ready,
//   flush squashes everything, NOP/0 presented on the head when empty, and a
//   sticky halt_seen set once decode consumes a HALT (opcode 5'b00000).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   q (slave) : f_valid/f_ready/f_instr/f_pc2 fetch side,
//               d_valid/d_ready/d_instr/d_pc2 decode side,
//               flush in, halt_seen/count out
module if_id_queue #(
  parameter int          DEPTH = 2,
  parameter logic [15:0] NOP   = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic            halt_q;
  logic            full, empty, push, pop;
  entry_t          head;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  // f_ready comes from registered state only: a pop while full does not
  // open a slot in the same cycle.
  assign q.f_ready   = !full && !halt_q;
  assign q.d_valid   = !empty;
  assign q.d_instr   = empty ? NOP   : head.instr;
  assign q.d_pc2     = empty ? 16'h0 : head.pc2;
  assign q.halt_seen = halt_q;
  assign q.count     = cnt;

  assign push = q.f_valid && q.f_ready && !q.flush;
  assign pop  = q.d_valid && q.d_ready && !q.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{instr: NOP, pc2: 16'h0};
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: q.f_instr, pc2: q.f_pc2};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head.instr[15:11] == 5'b00000) halt_q <= 1'b1;
      end
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven check of if_id_queue (DEPTH=2) plus
// hand-written async-reset sequence.
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_queue_if #(.DEPTH(2)) bus ();
  if_id_queue #(.DEPTH(2), .NOP(16'h0800)) dut (.clk(clk), .rst(rst), .q(bus));

  typedef struct {
    logic        f_valid;
    logic        d_ready;
    logic        flush;
    logic [15:0] f_instr;
    logic [15:0] f_pc2;
    logic        e_d_valid;
    logic        e_f_ready;
    logic [15:0] e_d_instr;
    logic [15:0] e_d_pc2;
    logic [1:0]  e_count;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic fv, logic dr, logic fl, logic [15:0] fi,
                              logic [15:0] fp, logic edv, logic efr,
                              logic [15:0] edi, logic [15:0] edp,
                              logic [1:0] ec, logic eh);
    vec_t v;
    v.f_valid = fv; v.d_ready = dr; v.flush = fl; v.f_instr = fi; v.f_pc2 = fp;
    v.e_d_valid = edv; v.e_f_ready = efr; v.e_d_instr = edi; v.e_d_pc2 = edp;
    v.e_count = ec; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic dv, input logic fr,
                         input logic [15:0] di, input logic [15:0] dp,
                         input logic [1:0] c, input logic h);
    chk({tag, " d_valid"},   16'(bus.d_valid),   16'(dv));
    chk({tag, " f_ready"},   16'(bus.f_ready),   16'(fr));
    chk({tag, " d_instr"},   bus.d_instr,        di);
    chk({tag, " d_pc2"},     bus.d_pc2,          dp);
    chk({tag, " count"},     16'(bus.count),     16'(c));
    chk({tag, " halt_seen"}, 16'(bus.halt_seen), 16'(h));
  endtask

  task automatic drive(input logic fv, input logic dr, input logic fl,
                       input logic [15:0] fi, input logic [15:0] fp);
    bus.f_valid = fv; bus.d_ready = dr; bus.flush = fl;
    bus.f_instr = fi; bus.f_pc2 = fp;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    //          fv dr fl instr    pc2      dv fr d_instr  d_pc2    cnt halt
    // fill to full, third push ignored
    vecs.push_back(mk(1, 0, 0, 16'h4102, 16'd2,  1, 1, 16'h4102, 16'd2,  2'd1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h4203, 16'd4,  1, 0, 16'h4102, 16'd2,  2'd2, 0));
    vecs.push_back(mk(1, 0, 0, 16'h4304, 16'd6,  1, 0, 16'h4102, 16'd2,  2'd2, 0));
    // full + pop + f_valid: only the pop happens
    vecs.push_back(mk(1, 1, 0, 16'h4304, 16'd6,  1, 1, 16'h4203, 16'd4,  2'd1, 0));
    // C accepted into wrapped slot
    vecs.push_back(mk(1, 0, 0, 16'h4304, 16'd6,  1, 0, 16'h4203, 16'd4,  2'd2, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    16'd0,  1, 1, 16'h4304, 16'd6,  2'd1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    16'd0,  0, 1, 16'h0800, 16'd0,  2'd0, 0));
    // empty: d_ready ignored
    vecs.push_back(mk(0, 1, 0, 16'h0,    16'd0,  0, 1, 16'h0800, 16'd0,  2'd0, 0));
    // flush at count=2 with push and pop requested
    vecs.push_back(mk(1, 0, 0, 16'h4405, 16'd8,  1, 1, 16'h4405, 16'd8,  2'd1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h4506, 16'd10, 1, 0, 16'h4405, 16'd8,  2'd2, 0));
    vecs.push_back(mk(1, 1, 1, 16'h4607, 16'd12, 0, 1, 16'h0800, 16'd0,  2'd0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h4708, 16'd14, 1, 1, 16'h4708, 16'd14, 2'd1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0,    16'd0,  0, 1, 16'h0800, 16'd0,  2'd0, 0));
    // HALT: sits at head without effect until popped
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'd16, 1, 1, 16'h0000, 16'd16, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0,    16'd0,  1, 1, 16'h0000, 16'd16, 2'd1, 0));
    // pop HALT with simultaneous push
    vecs.push_back(mk(1, 1, 0, 16'h4809, 16'd18, 1, 0, 16'h4809, 16'd18, 2'd1, 1));
    // halted: fetch refused, remaining entry drains
    vecs.push_back(mk(1, 0, 0, 16'h4A0A, 16'd20, 1, 0, 16'h4809, 16'd18, 2'd1, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0,    16'd0,  0, 0, 16'h0800, 16'd0,  2'd0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0,    16'd0,  0, 1, 16'h0800, 16'd0,  2'd0, 0));
    // one entry left in queue for the async reset sequence
    vecs.push_back(mk(1, 0, 0, 16'h4B0B, 16'd22, 1, 1, 16'h4B0B, 16'd22, 2'd1, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b1, 16'h0800, 16'h0, 2'd0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].f_valid, vecs[i].d_ready, vecs[i].flush,
            vecs[i].f_instr, vecs[i].f_pc2);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_d_valid, vecs[i].e_f_ready,
              vecs[i].e_d_instr, vecs[i].e_d_pc2, vecs[i].e_count, vecs[i].e_halt);
    end

    // async reset mid-cycle with count=1: outputs clear before next edge
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b1, 16'h0800, 16'h0, 2'd0, 1'b0);
    #2 rst = 1'b0;

    // first push after reset: not visible until after the edge
    drive(1'b1, 1'b0, 1'b0, 16'h4C0C, 16'd24);
    #1;
    chk("post_rst pre-edge d_valid", 16'(bus.d_valid), 16'd0);
    @(posedge clk);
    #1;
    chk_all("post_rst push", 1'b1, 1'b1, 16'h4C0C, 16'd24, 2'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
